// File: rtl/riscv_single_cycle_lsu.sv
// riscv_single_cycle_lsu: load/store unit for the RV32E single-cycle core.
// Runs one valid/ready memory transaction per load/store and stalls the core
// until it completes, returning extended load data or a fault.
// Optional feature macro: RISCV_LSU_MISALIGN_TRAP_EN (misaligned accesses fault
// instead of having their low address bits masked).
module riscv_single_cycle_lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_be,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             done_d, fault_d;
  logic [1:0]       cause_d;
  logic [31:0]      rdata_d;
  logic             mreq_valid_d, mreq_we_d;
  logic [31:0]      mreq_addr_d, mreq_wdata_d;
  logic [3:0]       mreq_be_d;

  logic             illegal_c, misalign_c;
  logic [1:0]       off_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      shifted_c, load_data_c;

  // Decode the incoming request: legality, alignment, lane offset, strobes, store data.
  always_comb begin
    illegal_c  = req_we ? (req_funct3 >= 3'd3)
                        : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    misalign_c = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misalign_c = req_addr[0];
      2'b10:   misalign_c = (req_addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
`else
    misalign_c = 1'b0;
`endif
    // Halfwords and words drop the sub-size address bits and proceed aligned.
    off_c = req_addr[1:0];
    if (req_funct3[1:0] == 2'b01) off_c[0] = 1'b0;
    if (req_funct3[1:0] == 2'b10) off_c = 2'b00;

    be_c    = 4'b1111;
    wdata_c = 32'd0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_c    = 4'b0001 << off_c;
          wdata_c = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << off_c;
          wdata_c = {2{req_wdata[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = req_wdata;
        end
      endcase
    end
  end

  // Align the response to lane 0 and extend according to the captured funct3.
  always_comb begin
    shifted_c = mem_rsp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'd1:    load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'd4:    load_data_c = {24'd0, shifted_c[7:0]};
      3'd5:    load_data_c = {16'd0, shifted_c[15:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  // Next-state and next-output logic; stall is the only combinational output.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    fault_d      = 1'b0;
    cause_d      = 2'b00;
    rdata_d      = 32'd0;
    mreq_valid_d = mem_req_valid;
    mreq_addr_d  = mem_req_addr;
    mreq_we_d    = mem_req_we;
    mreq_be_d    = mem_req_be;
    mreq_wdata_d = mem_req_wdata;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = off_c;
          if (illegal_c || misalign_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            cause_d = CAUSE_ALIGN;
          end else begin
            state_d      = REQ;
            mreq_valid_d = 1'b1;
            mreq_addr_d  = {req_addr[31:2], 2'b00};
            mreq_we_d    = req_we;
            mreq_be_d    = be_c;
            mreq_wdata_d = wdata_c;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          mreq_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        if (mem_rsp_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (mem_rsp_err) begin
            fault_d = 1'b1;
            cause_d = CAUSE_BUS;
          end else if (!we_q) begin
            rdata_d = load_data_c;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: begin
        // DONE: the core retires here; a still-high req_valid is the same instruction.
        state_d = IDLE;
      end
    endcase

    if (rst) stall = 1'b0;
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      off_q         <= 2'd0;
      cnt_q         <= '0;
      done          <= 1'b0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
      rdata         <= 32'd0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_we    <= 1'b0;
      mem_req_be    <= 4'd0;
      mem_req_wdata <= 32'd0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      cnt_q         <= cnt_d;
      done          <= done_d;
      fault         <= fault_d;
      fault_cause   <= cause_d;
      rdata         <= rdata_d;
      mem_req_valid <= mreq_valid_d;
      mem_req_addr  <= mreq_addr_d;
      mem_req_we    <= mreq_we_d;
      mem_req_be    <= mreq_be_d;
      mem_req_wdata <= mreq_wdata_d;
    end
  end

endmodule

// File: tb/tb_riscv_single_cycle_lsu.sv
// Testbench for riscv_single_cycle_lsu: directed cases plus randomized
// transactions checked against a byte-level reference model.
module tb_riscv_single_cycle_lsu;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = 32'd0;
  logic        mem_rsp_err = 1'b0;

  always #5 clk = ~clk;

  riscv_single_cycle_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  int checks = 0;
  int errors = 0;

  // Bus responder configuration, written only by the test process.
  int   cfg_ready_lat = 0;
  int   cfg_rsp_lat = 0;
  logic cfg_err = 1'b0;
  logic cfg_drop = 1'b0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Memory behind the bus, owned by the responder.
  logic [31:0] bus_mem [0:255];
  int          phase = 0;
  int          lat = 0;
  int          hs_count = 0;
  logic [31:0] cap_addr = 32'd0, cap_wdata = 32'd0, rsp_word = 32'd0;
  logic [3:0]  cap_be = 4'd0;
  logic        cap_we = 1'b0, cur_err = 1'b0;

  // Responder: drives ready/response on the falling edge from the configured latencies.
  always @(negedge clk) begin
    logic [31:0] word;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    mem_rsp_rdata = 32'd0;
    if (rst) begin
      phase = 0;
      mem_req_ready = 1'b0;
      for (int i = 0; i < 256; i++) bus_mem[i] = init_word(i);
    end else if (done === 1'b1) begin
      phase = 0;
      mem_req_ready = 1'b0;
    end else begin
      if (phase == 0 && mem_req_valid === 1'b1) begin
        lat = cfg_ready_lat;
        phase = 1;
      end
      if (phase == 1) begin
        if (lat == 0) begin
          mem_req_ready = 1'b1;
          hs_count++;
          cap_addr = mem_req_addr; cap_be = mem_req_be;
          cap_we = mem_req_we; cap_wdata = mem_req_wdata;
          cur_err = cfg_err;
          word = bus_mem[mem_req_addr[9:2]];
          if (mem_req_we && !cfg_err) begin
            for (int b = 0; b < 4; b++)
              if (mem_req_be[b]) word[8*b +: 8] = mem_req_wdata[8*b +: 8];
            bus_mem[mem_req_addr[9:2]] = word;
          end
          rsp_word = cfg_err ? $urandom() : word;
          lat = cfg_rsp_lat;
          phase = 2;
        end else begin
          lat--;
          mem_req_ready = 1'b0;
        end
      end else if (phase == 2) begin
        mem_req_ready = 1'b0;
        if (!cfg_drop) begin
          if (lat == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_err   = cur_err;
            mem_rsp_rdata = rsp_word;
            phase = 3;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // Reference model state: what memory should contain.
  logic [31:0] ref_mem [0:255];

  task automatic reinit_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // Reference model: RISC-V load/store semantics in bytes and integers.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err,
                       output logic e_fault, output logic [1:0] e_cause,
                       output logic [31:0] e_rdata, output logic e_bus,
                       output logic [31:0] e_addr, output logic [3:0] e_be,
                       output logic [31:0] e_wdata);
    int size, off, low;
    logic legal, mis, trap;
    longint unsigned v, mask;
    logic [31:0] word;
    e_fault = 1'b0; e_cause = 2'd0; e_rdata = 32'd0; e_bus = 1'b0;
    e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
      e_fault = 1'b1; e_cause = 2'd1;
      return;
    end
    size = 1 << (int'(f3) % 4);
    low  = int'(addr[1:0]);
    mis  = (low % size) != 0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    if (trap) begin
      e_fault = 1'b1; e_cause = 2'd1;
      return;
    end
    off     = low - (low % size);
    e_bus   = 1'b1;
    e_addr  = {addr[31:2], 2'b00};
    e_be    = we ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (we)
      for (int l = 0; l < 4; l++) e_wdata[8*l +: 8] = wdata[8*(l % size) +: 8];
    if (err) begin
      e_fault = 1'b1; e_cause = 2'd2;
      return;
    end
    word = ref_mem[addr[9:2]];
    if (we) begin
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[addr[9:2]] = word;
    end else begin
      v    = longint'(word) >> (8 * off);
      mask = (64'd1 << (8 * size)) - 64'd1;
      v    = v & mask;
      if (f3 < 3'd4 && v[8*size-1]) v = v | ~mask;
      e_rdata = v[31:0];
    end
  endtask

  // Observations from the last transaction.
  int          obs_cycle, obs_hs;
  logic        obs_fault, obs_stall_ok, obs_we;
  logic [1:0]  obs_cause;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  // Issue one instruction at a falling edge with DUT idle; cycle 0 is the accept cycle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rl, input int pl,
                         input logic err, input logic drop);
    int hs0;
    cfg_ready_lat = rl; cfg_rsp_lat = pl; cfg_err = err; cfg_drop = drop;
    hs0 = hs_count;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    obs_cycle = -1; obs_stall_ok = 1'b1;
    obs_fault = 1'b0; obs_cause = 2'd0; obs_rdata = 32'd0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) begin
        obs_cycle = c;
        obs_fault = fault; obs_cause = fault_cause; obs_rdata = rdata;
        if (stall !== 1'b0) obs_stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) obs_stall_ok = 1'b0;
      @(posedge clk); @(negedge clk); #1;
    end
    obs_hs = hs_count - hs0;
    obs_addr = cap_addr; obs_be = cap_be; obs_we = cap_we; obs_wdata = cap_wdata;
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall, done, rdata, fault, fault_cause, mem_req_valid, mem_req_addr, mem_req_we,
         mem_req_be, mem_req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b done=%b rdata=%h fault=%b cause=%b mrv=%b addr=%h we=%b be=%b wd=%h, expected all 0",
               stall, done, rdata, fault, fault_cause, mem_req_valid, mem_req_addr,
               mem_req_we, mem_req_be, mem_req_wdata);
    end
    rst = 1'b0;
    reinit_ref();
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_txn(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_cycle !== 3 || obs_fault !== 1'b0 || obs_rdata !== 32'd0) begin
      errors++;
      $display("FAIL sw_basic: got cycle=%0d fault=%b rdata=%h, expected 3 0 00000000", obs_cycle, obs_fault, obs_rdata);
    end
    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_cycle !== 3 || obs_rdata !== 32'hDEAD_BEEF || obs_fault !== 1'b0 || !obs_stall_ok) begin
      errors++;
      $display("FAIL lw_best_case: got cycle=%0d rdata=%h fault=%b stall_ok=%b, expected 3 deadbeef 0 1",
               obs_cycle, obs_rdata, obs_fault, obs_stall_ok);
    end
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b after DONE, expected 0", done);
    end
    run_txn(1'b1, 3'd2, 32'h100, 32'h80FF_FFFF, 0, 0, 1'b0, 1'b0);
    run_txn(1'b0, 3'd0, 32'h103, 32'h0, 1, 1, 1'b0, 1'b0);
    checks++;
    if (obs_rdata !== 32'hFFFF_FF80 || obs_cycle !== 5) begin
      errors++;
      $display("FAIL lb_sign: got rdata=%h cycle=%0d, expected ffffff80 5", obs_rdata, obs_cycle);
    end
    run_txn(1'b0, 3'd4, 32'h103, 32'h0, 0, 2, 1'b0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu_zero: got rdata=%h, expected 00000080", obs_rdata);
    end
    run_txn(1'b0, 3'd5, 32'h102, 32'h0, 2, 0, 1'b0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0000_80FF) begin
      errors++;
      $display("FAIL lhu_upper: got rdata=%h, expected 000080ff", obs_rdata);
    end
  endtask

  task automatic test_store_half();
    logic [31:0] w;
    run_txn(1'b1, 3'd1, 32'h206, 32'h1234_ABCD, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_addr !== 32'h204 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1) begin
      errors++;
      $display("FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b, expected 204 1100 abcdabcd 1",
               obs_addr, obs_be, obs_wdata, obs_we);
    end
    checks++;
    if (obs_fault !== 1'b0 || obs_rdata !== 32'd0 || obs_cycle !== 3) begin
      errors++;
      $display("FAIL sh_done: got fault=%b rdata=%h cycle=%0d, expected 0 0 3", obs_fault, obs_rdata, obs_cycle);
    end
    w = init_word(32'h204 >> 2);
    w[31:16] = 16'hABCD;
    run_txn(1'b0, 3'd2, 32'h204, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_rdata !== w) begin
      errors++;
      $display("FAIL sh_readback: got rdata=%h, expected %h", obs_rdata, w);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 3'd2, 32'h101, 32'h0, 0, 0, 1'b0, 1'b0);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    checks++;
    if (obs_cycle !== 1 || obs_fault !== 1'b1 || obs_cause !== 2'b01 || obs_hs !== 0) begin
      errors++;
      $display("FAIL lw_misaligned_trap: got cycle=%0d fault=%b cause=%b hs=%0d, expected 1 1 01 0",
               obs_cycle, obs_fault, obs_cause, obs_hs);
    end
`else
    checks++;
    if (obs_hs !== 1 || obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_fault !== 1'b0 ||
        obs_rdata !== 32'h80FF_FFFF) begin
      errors++;
      $display("FAIL lw_misaligned_mask: got hs=%0d addr=%h be=%b fault=%b rdata=%h, expected 1 100 1111 0 80ffffff",
               obs_hs, obs_addr, obs_be, obs_fault, obs_rdata);
    end
`endif
    run_txn(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_cycle !== 1 || obs_fault !== 1'b1 || obs_cause !== 2'b01 || obs_hs !== 0 || !obs_stall_ok) begin
      errors++;
      $display("FAIL load_illegal: got cycle=%0d fault=%b cause=%b hs=%0d, expected 1 1 01 0",
               obs_cycle, obs_fault, obs_cause, obs_hs);
    end
    run_txn(1'b1, 3'd3, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_cycle !== 1 || obs_fault !== 1'b1 || obs_cause !== 2'b01 || obs_hs !== 0) begin
      errors++;
      $display("FAIL store_illegal: got cycle=%0d fault=%b cause=%b hs=%0d, expected 1 1 01 0",
               obs_cycle, obs_fault, obs_cause, obs_hs);
    end
  endtask

  task automatic test_timeout();
    for (int rl = 0; rl <= 2; rl += 2) begin
      run_txn(1'b0, 3'd2, 32'h40, 32'h0, rl, 0, 1'b0, 1'b1);
      checks++;
      if (obs_cycle !== rl + 2 + int'(TO) + 1 || obs_fault !== 1'b1 || obs_cause !== 2'b11 ||
          obs_rdata !== 32'd0) begin
        errors++;
        $display("FAIL timeout_rl%0d: got cycle=%0d fault=%b cause=%b rdata=%h, expected %0d 1 11 0",
                 rl, obs_cycle, obs_fault, obs_cause, obs_rdata, rl + 2 + int'(TO) + 1);
      end
    end
  endtask

  task automatic test_bus_error();
    run_txn(1'b0, 3'd2, 32'h44, 32'h0, 1, 2, 1'b1, 1'b0);
    checks++;
    if (obs_cycle !== 6 || obs_fault !== 1'b1 || obs_cause !== 2'b10 || obs_rdata !== 32'd0) begin
      errors++;
      $display("FAIL bus_error: got cycle=%0d fault=%b cause=%b rdata=%h, expected 6 1 10 0",
               obs_cycle, obs_fault, obs_cause, obs_rdata);
    end
  endtask

  task automatic test_reset_in_req();
    cfg_ready_lat = 10; cfg_rsp_lat = 0; cfg_err = 1'b0; cfg_drop = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'd0;
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (mem_req_valid !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL req_asserted: got mem_req_valid=%b stall=%b, expected 1 1", mem_req_valid, stall);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if ({stall, done, rdata, fault, fault_cause, mem_req_valid, mem_req_addr, mem_req_we,
         mem_req_be, mem_req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_in_req: got stall=%b done=%b mrv=%b addr=%h be=%b, expected all 0",
               stall, done, mem_req_valid, mem_req_addr, mem_req_be);
    end
    rst = 1'b0;
    reinit_ref();
    @(negedge clk);
    run_txn(1'b1, 3'd2, 32'h300, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0);
    ref_mem[8'hC0] = 32'h0BAD_F00D;
    checks++;
    if (obs_cycle !== 3 || obs_fault !== 1'b0 || obs_addr !== 32'h300 || obs_be !== 4'b1111) begin
      errors++;
      $display("FAIL sw_after_reset: got cycle=%0d fault=%b addr=%h be=%b, expected 3 0 300 1111",
               obs_cycle, obs_fault, obs_addr, obs_be);
    end
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL sw_readback: got rdata=%h, expected 0badf00d", obs_rdata);
    end
  endtask

  task automatic test_random();
    logic we, er, e_fault, e_bus;
    logic [2:0] f3;
    logic [1:0] e_cause;
    logic [31:0] addr, wd, e_rdata, e_addr, e_wdata;
    logic [3:0] e_be;
    int rl, pl, k, e_cycle;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        k = $urandom_range(0, 4);
        f3 = (k > 2) ? 3'(k + 1) : 3'(k);
      end
      addr = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      wd = $urandom();
      rl = $urandom_range(0, 3);
      pl = $urandom_range(0, 3);
      er = ($urandom_range(0, 7) == 0);
      model(we, f3, addr, wd, er, e_fault, e_cause, e_rdata, e_bus, e_addr, e_be, e_wdata);
      run_txn(we, f3, addr, wd, rl, pl, er, 1'b0);
      e_cycle = e_bus ? rl + pl + 3 : 1;
      checks++;
      if (obs_cycle !== e_cycle || obs_fault !== e_fault || obs_cause !== e_cause ||
          obs_rdata !== e_rdata || !obs_stall_ok) begin
        errors++;
        $display("FAIL rand%0d_result: we=%b f3=%0d addr=%h got cycle=%0d fault=%b cause=%b rdata=%h stall_ok=%b, expected %0d %b %b %h 1",
                 n, we, f3, addr, obs_cycle, obs_fault, obs_cause, obs_rdata, obs_stall_ok,
                 e_cycle, e_fault, e_cause, e_rdata);
      end
      checks++;
      if (obs_hs !== (e_bus ? 1 : 0) ||
          (e_bus && (obs_addr !== e_addr || obs_be !== e_be || obs_we !== we)) ||
          (e_bus && we && obs_wdata !== e_wdata)) begin
        errors++;
        $display("FAIL rand%0d_bus: got hs=%0d addr=%h be=%b we=%b wdata=%h, expected %0d %h %b %b %h",
                 n, obs_hs, obs_addr, obs_be, obs_we, obs_wdata, e_bus ? 1 : 0, e_addr, e_be, we, e_wdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_bus_error();
    test_reset_in_req();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_single_cycle_lsu.md
# riscv_single_cycle_lsu

Load/store unit for the RV32E single-cycle core, directly downstream of the ALU. It takes the ALU result as the effective address, runs one memory transaction over a valid/ready bus, and stalls the core until the transaction completes. It returns lane-aligned, sign- or zero-extended load data to writeback, or reports a fault instead.

## Interface
Parameters:
- TIMEOUT, default 64: maximum number of cycles spent in WAIT before a timeout fault is raised. A value of 0 disables the timeout.

Ports:
- clk  in  1  core clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  the current instruction is a load or store; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  access width and signedness: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  freezes the core's PC and register-file write.
- done  out  1  one-cycle pulse; rdata/fault are valid in this cycle.
- rdata  out  32  extended load data; 0 for stores and faults.
- fault  out  1  the access failed; valid when done=1.
- fault_cause  out  2  01 misaligned or illegal width, 10 bus error, 11 timeout.
- mem_req_valid  out  1 / mem_req_ready  in  1  request handshake.
- mem_req_addr  out  32  word address ({addr[31:2],2'b00}).
- mem_req_we  out  1 / mem_req_be  out  4 / mem_req_wdata  out  32  lane-replicated store data.
- mem_rsp_valid  in  1 / mem_rsp_rdata  in  32 / mem_rsp_err  in  1  response; carries no ready signal.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid: capture we, funct3, addr, and wdata into registers.
  - If the check fails: go to DONE with fault and cause 01; no bus request is issued.
  - Otherwise: go to REQ.
- Check failures:
  - Illegal funct3: load funct3 in {3,6,7}, or store funct3 ≥3.
  - Misaligned address (see Configuration).
- REQ:
  - mem_req_valid=1 from the captured registers; stall=1.
  - On mem_req_ready: go to WAIT.
  - Request fields stay stable until the handshake.
- WAIT:
  - stall=1; the timeout counter increments every cycle.
  - On mem_rsp_valid: go to DONE. mem_rsp_err=1 gives fault with cause 10.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT before a response: go to DONE with fault and cause 11.
- DONE:
  - done=1, stall=0; the core retires the instruction on this edge.
  - Next state is IDLE unconditionally. req_valid in DONE is the same instruction and is ignored.
- Byte lanes, with off=addr[1:0]:
  - SB: be=4'b0001<<off, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<off, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads: be=4'b1111.
- Load data:
  - Shift the response right by 8*off, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - The result is registered into rdata on entry to DONE.
- A store that completes without error leaves rdata at 0.
- Responses arriving in IDLE, REQ or DONE are dropped. The bus must allow at most one outstanding request.
- Reset:
  - Returns to IDLE from any state; a transaction in flight is abandoned.
  - The memory model shares rst.
  - Outputs under reset: stall=0, done=0, rdata=0, fault=0, fault_cause=0, mem_req_valid=0, mem_req_addr=0, mem_req_we=0, mem_req_be=0, mem_req_wdata=0.
  - Timeout counter is cleared to 0.

## Timing
- Accepted in cycle 0 (IDLE). mem_req_valid is asserted from cycle 1.
- A response is no earlier than the cycle after the request handshake.
- Best case: ready in cycle 1, response in cycle 2, done in cycle 3. The core stalls for cycles 0–2.
- A fault detected at acceptance: done in cycle 1 with zero bus activity.
- Timeout: done at TIMEOUT+1 cycles after entering WAIT.
- The timeout counter clears on entry to WAIT and saturates; width is $clog2(TIMEOUT+1).
- done, fault, fault_cause and rdata are registered outputs. stall is combinational only in IDLE.

## Configuration
- RISCV_LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses fault with cause 01 and issue no bus request.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Undefined:
  - Misalignment is never a fault. The low address bits are masked: addr[0] for halfwords, addr[1:0] for words.
  - The access then proceeds as aligned.
  - Illegal funct3 still faults with cause 01.

## Test plan
- LW at 0x100; memory ready in cycle 1, response 0xDEADBEEF in cycle 2 -> done in cycle 3, rdata=0xDEADBEEF, stall high in cycles 0–2.
- LB at 0x103, word 0x80FF_FFFF -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SH at 0x206, wdata 0x1234ABCD -> mem_req_addr=0x204, be=4'b1100, wdata=0xABCDABCD; done with fault=0, rdata=0.
- LW at 0x101 with the macro defined -> no mem_req_valid, done in cycle 1, fault=1, cause=01. Without the macro -> request to 0x100, be=4'b1111.
- TIMEOUT=4 with no response -> fault with cause 11 at 5 cycles after WAIT entry. A response with mem_rsp_err=1 -> cause 10, rdata=0.
- ready held low for 3 cycles, then rst pulsed in REQ -> next cycle all outputs 0, state IDLE. A subsequent SW at 0x300 completes normally.
